// File: rtl/ecg_pkg.sv
// rtl/ecg_pkg.sv - shared ECG display RAM layout constants and writer state
package ecg_pkg;

  // RAM layout shared with the VGA waveform renderer
  localparam logic [11:0] ECG_BASE_ADDR = 12'h801;
  localparam int          ECG_DEPTH     = 640;
  localparam int          ECG_DATA_W    = 12;

  // Port widths of the writer bus
  localparam int ECG_ADDR_W = 12;
  localparam int ECG_COL_W  = 10;
  localparam int ECG_WORD_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    WRITE = 1'b1
  } writer_state_e;

endpackage

// File: rtl/ecg_sample_writer_if.sv
// rtl/ecg_sample_writer_if.sv - sample stream, control and RAM write bus of the ECG writer
interface ecg_sample_writer_if;
  import ecg_pkg::*;

  logic                  sample_valid;
  logic [ECG_DATA_W-1:0] sample_data;
  logic                  sample_ready;
  logic                  freeze;
  logic                  clear;
  logic                  mem_we;
  logic [ECG_ADDR_W-1:0] mem_addr;
  logic [ECG_WORD_W-1:0] mem_wdata;
  logic [ECG_COL_W-1:0]  wr_col;
  logic                  frame_wrap;

  modport slave (
    input  sample_valid, sample_data, freeze, clear,
    output sample_ready, mem_we, mem_addr, mem_wdata, wr_col, frame_wrap
  );

  modport master (
    output sample_valid, sample_data, freeze, clear,
    input  sample_ready, mem_we, mem_addr, mem_wdata, wr_col, frame_wrap
  );

endinterface

// File: rtl/ecg_decimator.sv
// rtl/ecg_decimator.sv - accumulates groups of 2^DECIM_LOG2 samples into one truncated average
module ecg_decimator #(
  parameter int DATA_W     = 12,
  parameter int DECIM_LOG2 = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_accept,
  input  logic [DATA_W-1:0] in_data,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_data
);

  // acc holds at most 2^DECIM_LOG2-1 full-scale samples, so the final sum fits too
  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum;

  // Average is offered in the same cycle the last sample of a group is accepted
  always_comb begin
    sum       = acc_q + ACC_W'(in_data);
    avg_valid = in_accept && (cnt_q == CNT_LAST);
    avg_data  = DATA_W'(sum >> DECIM_LOG2);
  end

  // Partial sums survive idle or frozen cycles; clear and group completion restart them
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear || avg_valid) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_accept) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Accumulator and group counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ecg_sample_writer.sv
// rtl/ecg_sample_writer.sv - decimates ECG samples and writes one RAM word per screen column
module ecg_sample_writer
  import ecg_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR  = ECG_BASE_ADDR,
  parameter int          DEPTH      = ECG_DEPTH,
  parameter int          DECIM_LOG2 = 2,
  parameter int          DATA_W     = ECG_DATA_W
) (
  input logic                 clock,
  input logic                 reset,
  ecg_sample_writer_if.slave  bus
);

  localparam logic [ECG_COL_W-1:0] COL_LAST = ECG_COL_W'(DEPTH - 1);

  writer_state_e         state_q, state_d;
  logic [ECG_COL_W-1:0]  wr_col_q, wr_col_d;
  logic [ECG_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  frame_wrap_q, frame_wrap_d;
  logic                  accept;
  logic                  avg_valid;
  logic [DATA_W-1:0]     avg_data;

  // Samples are taken only in ACCUM, so ready drops for the single WRITE cycle
  always_comb begin
    bus.sample_ready = (state_q == ACCUM) && !bus.freeze && !bus.clear;
    accept           = bus.sample_valid && bus.sample_ready;
  end

  ecg_decimator #(
    .DATA_W     (DATA_W),
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_decimator (
    .clock     (clock),
    .reset     (reset),
    .clear     (bus.clear),
    .in_accept (accept),
    .in_data   (bus.sample_data),
    .avg_valid (avg_valid),
    .avg_data  (avg_data)
  );

  // Writer state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // WRITE lasts exactly one cycle; clear overrides everything
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (avg_valid) state_d = WRITE;
        WRITE:   state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Bus outputs; mem_we is the WRITE state itself so it is glitch-free
  always_comb begin
    bus.mem_we     = (state_q == WRITE);
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = ECG_WORD_W'(mem_wdata_q);
    bus.wr_col     = wr_col_q;
    bus.frame_wrap = frame_wrap_q;
  end

  // Latch address/data with the last sample, advance the column when the write retires
  always_comb begin
    wr_col_d     = wr_col_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    frame_wrap_d = 1'b0;
    if (bus.clear) begin
      wr_col_d   = '0;
      mem_addr_d = BASE_ADDR;
    end else begin
      if (avg_valid) begin
        mem_addr_d  = BASE_ADDR + ECG_ADDR_W'(wr_col_q);
        mem_wdata_d = avg_data;
      end
      if (state_q == WRITE) begin
        if (wr_col_q == COL_LAST) begin
          wr_col_d     = '0;
          frame_wrap_d = 1'b1;
        end else begin
          wr_col_d = wr_col_q + 1'b1;
        end
      end
    end
  end

  // Column, address, data and wrap registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_col_q     <= '0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= '0;
      frame_wrap_q <= 1'b0;
    end else begin
      wr_col_q     <= wr_col_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      frame_wrap_q <= frame_wrap_d;
    end
  end

endmodule

// File: tb/tb_ecg_sample_writer.sv
// tb/tb_ecg_sample_writer.sv - self-checking bench for ecg_sample_writer
module tb_ecg_sample_writer;
  import ecg_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ecg_sample_writer_if if_a ();
  ecg_sample_writer_if if_b ();

  ecg_sample_writer #(.BASE_ADDR(12'h801), .DEPTH(640), .DECIM_LOG2(2), .DATA_W(12)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.slave)
  );

  ecg_sample_writer #(.BASE_ADDR(12'h801), .DEPTH(640), .DECIM_LOG2(0), .DATA_W(12)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wrap_cnt = 0;
  logic [43:0] wr_log[$];
  logic [43:0] exp_q[$];

  // reference model: group of four samples -> floor(mean), column index modulo 640
  int          m_col = 0;
  int unsigned m_sum = 0;
  int          m_n   = 0;

  always @(negedge clock) begin
    if (if_a.mem_we === 1'b1) wr_log.push_back({if_a.mem_addr, if_a.mem_wdata});
    if (if_a.frame_wrap === 1'b1) wrap_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_col = 0; m_sum = 0; m_n = 0;
  endtask

  task automatic model_accept(input logic [11:0] d);
    m_sum += d;
    m_n++;
    if (m_n == 4) begin
      exp_q.push_back({12'(32'h801 + m_col), 32'(m_sum / 4)});
      m_col = (m_col + 1) % 640;
      m_sum = 0;
      m_n   = 0;
    end
  endtask

  function automatic logic [43:0] last_log();
    if (wr_log.size() == 0) return 'x;
    return wr_log[wr_log.size()-1];
  endfunction

  task automatic send_a(input logic [11:0] d);
    int budget;
    budget = 20;
    @(negedge clock);
    if_a.sample_valid = 1'b1;
    if_a.sample_data  = d;
    #1;
    while (if_a.sample_ready !== 1'b1 && budget > 0) begin
      @(negedge clock); #1; budget--;
    end
    if (budget == 0) chk("accept_wait_a", 64'(if_a.sample_ready), 64'(1));
    else begin
      @(posedge clock); #1;
      model_accept(d);
    end
  endtask

  task automatic send_b(input logic [11:0] d);
    int budget;
    budget = 20;
    @(negedge clock);
    if_b.sample_valid = 1'b1;
    if_b.sample_data  = d;
    #1;
    while (if_b.sample_ready !== 1'b1 && budget > 0) begin
      @(negedge clock); #1; budget--;
    end
    if (budget == 0) chk("accept_wait_b", 64'(if_b.sample_ready), 64'(1));
    else begin
      @(posedge clock); #1;
    end
  endtask

  task automatic idle_a(input int n);
    @(negedge clock);
    if_a.sample_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic drain_check(input string tag);
    int n;
    chk({tag, "_writes"}, 64'(wr_log.size()), 64'(exp_q.size()));
    n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 64'(wr_log[i][43:32]), 64'(exp_q[i][43:32]));
      chk({tag, "_data"}, 64'(wr_log[i][31:0]), 64'(exp_q[i][31:0]));
    end
    wr_log.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] r;
    int frz_ready;
    int wrap0;
    int n_grp;

    if_a.sample_valid = 0; if_a.sample_data = 0; if_a.freeze = 0; if_a.clear = 0;
    if_b.sample_valid = 0; if_b.sample_data = 0; if_b.freeze = 0; if_b.clear = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_we",     64'(if_a.mem_we),     64'(0));
    chk("rst_addr",   64'(if_a.mem_addr),   64'(12'h801));
    chk("rst_wdata",  64'(if_a.mem_wdata),  64'(0));
    chk("rst_col",    64'(if_a.wr_col),     64'(0));
    chk("rst_wrap",   64'(if_a.frame_wrap), 64'(0));
    chk("rst_ready",  64'(if_a.sample_ready), 64'(1));
    chk("rst_b_addr", 64'(if_b.mem_addr),   64'(12'h801));
    if_a.freeze = 1'b1; #1;
    chk("rst_ready_frz", 64'(if_a.sample_ready), 64'(0));
    if_a.freeze = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_clear();

    // unaveraged instance: write in the cycle after acceptance
    send_b(12'd37);
    if_b.sample_valid = 1'b0;
    chk("b_we",    64'(if_b.mem_we),       64'(1));
    chk("b_data",  64'(if_b.mem_wdata),    64'(37));
    chk("b_addr",  64'(if_b.mem_addr),     64'(12'h801));
    chk("b_ready", 64'(if_b.sample_ready), 64'(0));
    @(posedge clock); #1;
    chk("b_we_after", 64'(if_b.mem_we), 64'(0));
    chk("b_col",      64'(if_b.wr_col), 64'(1));
    r = 12'($urandom);
    send_b(r);
    if_b.sample_valid = 1'b0;
    chk("b_data2", 64'(if_b.mem_wdata), 64'(r));
    chk("b_addr2", 64'(if_b.mem_addr),  64'(12'h802));

    // first group, back-to-back
    send_a(12'd100); chk("t1_ready1", 64'(if_a.sample_ready), 64'(1));
    send_a(12'd200); chk("t1_ready2", 64'(if_a.sample_ready), 64'(1));
    send_a(12'd300); chk("t1_ready3", 64'(if_a.sample_ready), 64'(1));
    send_a(12'd400);
    if_a.sample_valid = 1'b0;
    chk("t1_we",       64'(if_a.mem_we),       64'(1));
    chk("t1_addr",     64'(if_a.mem_addr),     64'(12'h801));
    chk("t1_data",     64'(if_a.mem_wdata),    64'(250));
    chk("t1_ready_wr", 64'(if_a.sample_ready), 64'(0));
    chk("t1_col_wr",   64'(if_a.wr_col),       64'(0));
    @(posedge clock); #1;
    chk("t1_we_after",    64'(if_a.mem_we),       64'(0));
    chk("t1_col_after",   64'(if_a.wr_col),       64'(1));
    chk("t1_ready_after", 64'(if_a.sample_ready), 64'(1));
    idle_a(2);
    drain_check("t1");

    // truncating average
    send_a(12'd1); send_a(12'd1); send_a(12'd1); send_a(12'd2);
    idle_a(3);
    chk("trunc_data", 64'(last_log()), 64'({12'h802, 32'd1}));
    drain_check("trunc");

    // freeze keeps the partial group
    send_a(12'd10); send_a(12'd20);
    @(negedge clock);
    if_a.freeze = 1'b1;
    if_a.sample_valid = 1'b1;
    frz_ready = 0;
    for (int i = 0; i < 50; i++) begin
      if_a.sample_data = 12'($urandom);
      #1;
      if (if_a.sample_ready !== 1'b0) frz_ready++;
      @(negedge clock);
    end
    if_a.freeze = 1'b0;
    if_a.sample_valid = 1'b0;
    chk("frz_ready_cycles", 64'(frz_ready), 64'(0));
    chk("frz_writes",       64'(wr_log.size()), 64'(0));
    chk("frz_col",          64'(if_a.wr_col), 64'(m_col));
    send_a(12'd30); send_a(12'd40);
    idle_a(3);
    chk("frz_data", 64'(last_log()), 64'({12'h803, 32'd25}));
    drain_check("freeze");

    // random groups with random idle gaps
    for (int g = 0; g < 40; g++) begin
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(0, 3) == 0) idle_a(1);
        send_a(12'($urandom));
      end
    end
    idle_a(3);
    chk("rand_col", 64'(if_a.wr_col), 64'(m_col));
    drain_check("rand");

    // full sweep to the last column and wrap
    wrap0 = wrap_cnt;
    n_grp = 640 - m_col;
    for (int g = 0; g < n_grp; g++) repeat (4) send_a(12'hFFF);
    idle_a(3);
    chk("wrap_pulses", 64'(wrap_cnt - wrap0), 64'(1));
    chk("wrap_col",    64'(if_a.wr_col), 64'(0));
    chk("wrap_last",   64'(last_log()), 64'({12'hA80, 32'hFFF}));
    drain_check("wrap");
    repeat (4) send_a(12'd8);
    idle_a(3);
    chk("after_wrap_addr", 64'(last_log()), 64'({12'h801, 32'd8}));
    drain_check("after_wrap");

    // clear during the WRITE cycle of column 5
    @(negedge clock);
    if_a.sample_valid = 1'b0;
    if_a.clear = 1'b1;
    @(negedge clock);
    if_a.clear = 1'b0;
    model_clear();
    chk("clr_col0", 64'(if_a.wr_col), 64'(0));
    for (int g = 0; g < 5; g++) repeat (4) send_a(12'($urandom));
    repeat (4) send_a(12'($urandom));
    if_a.sample_valid = 1'b0;
    chk("clr_we_wr",   64'(if_a.mem_we),   64'(1));
    chk("clr_addr_wr", 64'(if_a.mem_addr), 64'(12'h806));
    if_a.clear = 1'b1;
    @(posedge clock); #1;
    chk("clr_we",   64'(if_a.mem_we),     64'(0));
    chk("clr_col",  64'(if_a.wr_col),     64'(0));
    chk("clr_addr", 64'(if_a.mem_addr),   64'(12'h801));
    chk("clr_wrap", 64'(if_a.frame_wrap), 64'(0));
    @(negedge clock);
    if_a.clear = 1'b0;
    model_clear();
    repeat (4) send_a(12'($urandom));
    idle_a(3);
    chk("clr_next_addr", 64'(last_log() >> 32), 64'(12'h801));
    drain_check("clear");

    // asynchronous reset in the middle of a group
    repeat (8) send_a(12'($urandom));
    idle_a(2);
    chk("pre_rst_col", 64'(if_a.wr_col), 64'(3));
    drain_check("pre_reset");
    send_a(12'($urandom)); send_a(12'($urandom));
    @(negedge clock);
    if_a.sample_valid = 1'b0;
    #2;
    if_a.freeze = 1'b1;
    reset = 1'b0;
    #1;
    chk("mrst_we",    64'(if_a.mem_we),       64'(0));
    chk("mrst_wrap",  64'(if_a.frame_wrap),   64'(0));
    chk("mrst_col",   64'(if_a.wr_col),       64'(0));
    chk("mrst_addr",  64'(if_a.mem_addr),     64'(12'h801));
    chk("mrst_wdata", 64'(if_a.mem_wdata),    64'(0));
    chk("mrst_ready", 64'(if_a.sample_ready), 64'(0));
    if_a.freeze = 1'b0;
    #1;
    chk("mrst_ready_nf", 64'(if_a.sample_ready), 64'(1));
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    repeat (3) send_a(12'($urandom));
    idle_a(4);
    chk("post_rst_nowrite", 64'(wr_log.size()), 64'(0));
    send_a(12'($urandom));
    idle_a(3);
    drain_check("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ecg_sample_writer.md
Name: ecg_sample_writer

Overview:
- Producer side of the ECG display RAM that the VGA waveform renderer reads.
- Accepts 12-bit ECG samples over a valid/ready handshake and averages each group of 2^DECIM_LOG2 samples into one column value.
- Writes column values to RAM in sweep order, one word per screen column, from BASE_ADDR to BASE_ADDR+DEPTH-1, then wraps to column 0.
- Exposes the current write column and a wrap pulse so the display can draw a sweep cursor.

Parameters:
- BASE_ADDR, 12'h801: RAM word address of screen column 0.
- DEPTH, 640: number of columns; one word per column.
- DECIM_LOG2, 2: log2 of samples averaged per column. Legal range 0..4; 0 means every sample is written unaveraged.
- DATA_W, 12: ECG sample width.

Ports:
- clock  in  1: system clock. All logic uses the rising edge.
- reset  in  1: asynchronous, active-low reset.
- sample_valid  in  1: sample_data is valid this cycle.
- sample_data  in  12: unsigned ECG sample.
- sample_ready  out  1: block accepts a sample this cycle.
- freeze  in  1: hold the trace; stop accepting samples.
- clear  in  1: synchronous restart of the sweep.
- mem_we  out  1: RAM write enable, one-cycle pulse.
- mem_addr  out  12: RAM word address.
- mem_wdata  out  32: bits [11:0] hold the averaged sample; bits [31:12] are always 0.
- wr_col  out  10: next column to be written, 0..DEPTH-1.
- frame_wrap  out  1: one-cycle pulse when wr_col wraps from DEPTH-1 to 0.

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - state=ACCUM, acc=0, cnt=0, wr_col=0.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, frame_wrap=0.
- sample_ready is combinational: (state==ACCUM) && !freeze && !clear. Its value during reset is therefore !freeze.
- A sample is accepted on any clock edge where sample_valid && sample_ready.
- ACCUM state:
  - On acceptance with cnt < 2^DECIM_LOG2-1: acc += sample_data; cnt++.
  - On acceptance with cnt == 2^DECIM_LOG2-1:
    - mem_wdata[11:0] <= (acc + sample_data) >> DECIM_LOG2, truncating.
    - mem_addr <= BASE_ADDR + wr_col.
    - mem_we <= 1; acc <= 0; cnt <= 0; state <= WRITE.
- WRITE state (exactly one cycle):
  - mem_we is high for this single cycle.
  - At the end of the cycle: mem_we <= 0; state <= ACCUM.
  - If wr_col == DEPTH-1: wr_col <= 0 and frame_wrap <= 1 for one cycle. Otherwise wr_col++.
- Latency:
  - Last sample of a group accepted at edge N: mem_we is high from edge N until edge N+1.
  - wr_col updates at edge N+1.
  - sample_ready is low for that one cycle, so peak throughput is 2^DECIM_LOG2 samples per 2^DECIM_LOG2+1 cycles.
- Arithmetic:
  - acc is DATA_W+DECIM_LOG2 bits wide and cannot overflow.
  - mem_addr = BASE_ADDR + wr_col, computed in 12 bits with no wrap: BASE_ADDR+DEPTH-1 ≤ 12'hFFF is a parameter legality requirement.
- freeze:
  - Deasserts sample_ready only.
  - Partial acc/cnt are retained, so the group resumes where it stopped.
  - A WRITE already in progress completes.
  - wr_col is unchanged.
- clear:
  - Highest priority in any state.
  - Next edge: state=ACCUM, acc=0, cnt=0, wr_col=0, mem_we=0, frame_wrap=0, mem_addr=BASE_ADDR.
  - An in-flight WRITE is cut to the cycle already issued; no further write occurs for that group.
- Simultaneous clear and freeze: clear applies; sample_ready stays low while freeze is held.
- sample_data is ignored whenever sample_ready=0.
- mem_addr and mem_wdata hold their last values while mem_we=0.

Decomposition:
- Package ecg_pkg holds:
  - ECG_BASE_ADDR (12'h801), ECG_DEPTH (640), ECG_DATA_W (12).
  - The writer state enum {ACCUM, WRITE}.
  - The renderer shares these constants so both ends agree on the RAM layout.
- Sub-module ecg_decimator: acc/cnt, accumulate-and-shift, one-cycle avg_valid output, and a clear input.
- Top level holds the WRITE FSM, column counter, address generation, and handshake logic.

Test Plan:
- DECIM_LOG2=2, samples 100, 200, 300, 400 back-to-back -> single mem_we pulse with mem_wdata=32'd250, mem_addr=12'h801; wr_col goes 0→1; sample_ready low only during the write cycle.
- 640 groups of four 12'hFFF samples -> last write at mem_addr=12'hA80 with mem_wdata=32'hFFF; frame_wrap pulses once; wr_col=0; next write at 12'h801.
- Truncation: samples 1, 1, 1, 2 -> mem_wdata=1. DECIM_LOG2=0 with sample 37 -> mem_wdata=37, written one cycle after acceptance.
- Accept 10, 20; assert freeze for 50 cycles with sample_valid=1 -> no acceptance and no mem_we. Release freeze, accept 30, 40 -> mem_wdata=25.
- Assert clear on the WRITE cycle of column 5 -> mem_we=0 next cycle, wr_col=0. The next complete group writes to 12'h801.
- Drop reset mid-group with no clock edge -> mem_we, frame_wrap, and wr_col read 0 and mem_addr reads 12'h801 immediately. After release, a fresh group of four samples is needed before any write.
